// File: rtl/counter_pkg.sv
// Shared types and default widths for the counter sequencer slice.
package counter_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned DIV_WIDTH  = 8;
   localparam int unsigned RELOAD_W   = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } ctrl_state_t;

   typedef enum logic {
      ONE_SHOT,
      AUTO_RELOAD
   } ctrl_mode_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command channel from the host side into counter_ctrl.
interface counter_ctrl_if
   import counter_pkg::*;
#(
   parameter int unsigned Data_Width = DATA_WIDTH,
   parameter int unsigned Div_Width  = DIV_WIDTH
) ();

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [Data_Width-1:0] cmd_start;
   logic [Data_Width-1:0] cmd_limit;
   logic                  cmd_reload;
   logic [Div_Width-1:0]  cmd_div;

   modport master (
      output cmd_valid, cmd_start, cmd_limit, cmd_reload, cmd_div,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_start, cmd_limit, cmd_reload, cmd_div,
      output cmd_ready
   );

endinterface

// File: rtl/Counter.sv
// Loadable up-counter: reset, then load, then increment (ld beats en).
module Counter #(
   parameter int unsigned Data_Width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld,
   input  logic                  en,
   input  logic [Data_Width-1:0] datain,
   output logic [Data_Width-1:0] dataout
);

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     dataout <= '0;
      else if (ld) dataout <= datain;
      else if (en) dataout <= dataout + Data_Width'(1);
   end

endmodule

// File: rtl/tick_gen.sv
// Prescaler: tick when p == div, p wraps to 0 after the tick cycle.
module tick_gen
   import counter_pkg::*;
#(
   parameter int unsigned Div_Width = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 run,
   input  logic [Div_Width-1:0] div,
   output logic                 tick
);

   logic [Div_Width-1:0] p_q;

   assign tick = (p_q == div);

   // Prescale count, cleared on each counter load
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        p_q <= '0;
      else if (clear) p_q <= '0;
      else if (run)   p_q <= tick ? '0 : p_q + Div_Width'(1);
   end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for one Counter: load, prescaled run, terminal detect.
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int unsigned Data_Width = DATA_WIDTH,
   parameter int unsigned Div_Width  = DIV_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   counter_ctrl_if.slave         cmd,
   input  logic                  abort,
   output logic                  ctr_ld,
   output logic                  ctr_en,
   output logic [Data_Width-1:0] ctr_datain,
   input  logic [Data_Width-1:0] ctr_dataout,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [RELOAD_W-1:0]   reload_cnt
);

   ctrl_state_t           state_q, state_d;
   ctrl_mode_t            mode_q;
   logic [Data_Width-1:0] start_q, limit_q;
   logic [Div_Width-1:0]  div_q;
   logic                  accept, reload_inc, presc_clear, presc_run, tick;
   logic                  at_limit;

   assign at_limit       = (ctr_dataout == limit_q);
   assign ctr_datain     = start_q;
   assign busy           = (state_q != IDLE);
   assign cmd.cmd_ready  = (state_q == IDLE);

   tick_gen #(.Div_Width(Div_Width)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (presc_clear),
      .run   (presc_run),
      .div   (div_q),
      .tick  (tick)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and counter controls; abort overrides everything outside IDLE
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      ctr_ld      = 1'b0;
      ctr_en      = 1'b0;
      done        = 1'b0;
      aborted     = 1'b0;
      reload_inc  = 1'b0;
      presc_clear = 1'b0;
      presc_run   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               accept  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            ctr_ld      = 1'b1;
            presc_clear = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            presc_run = 1'b1;
            if (at_limit) begin
               done = 1'b1;
               if (mode_q == AUTO_RELOAD) begin
                  reload_inc = 1'b1;
                  state_d    = LOAD;
               end else begin
                  state_d = DONE;
               end
            end else begin
               ctr_en = tick;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && (state_q != IDLE)) begin
         state_d    = IDLE;
         ctr_ld     = 1'b0;
         ctr_en     = 1'b0;
         done       = 1'b0;
         reload_inc = 1'b0;
         aborted    = 1'b1;
      end
   end

   // Command field capture on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= '0;
         limit_q <= '0;
         div_q   <= '0;
         mode_q  <= ONE_SHOT;
      end else if (accept) begin
         start_q <= cmd.cmd_start;
         limit_q <= cmd.cmd_limit;
         div_q   <= cmd.cmd_div;
         mode_q  <= cmd.cmd_reload ? AUTO_RELOAD : ONE_SHOT;
      end
   end

   // Completed-period counter, restarted by every accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             reload_cnt <= '0;
      else if (accept)     reload_cnt <= '0;
      else if (reload_inc) reload_cnt <= reload_cnt + RELOAD_W'(1);
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench: counter_ctrl driving a real Counter, scoreboarded per period.
module tb_counter_ctrl;
   import counter_pkg::*;

   localparam int unsigned DW = DATA_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          abort;
   logic          ctr_ld, ctr_en, busy, done, aborted;
   logic [DW-1:0] ctr_datain, ctr_dataout;
   logic [7:0]    reload_cnt;

   counter_ctrl_if #(.Data_Width(DW), .Div_Width(DIV_WIDTH)) cmd_if ();

   counter_ctrl #(.Data_Width(DW), .Div_Width(DIV_WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd_if.slave),
      .abort       (abort),
      .ctr_ld      (ctr_ld),
      .ctr_en      (ctr_en),
      .ctr_datain  (ctr_datain),
      .ctr_dataout (ctr_dataout),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .reload_cnt  (reload_cnt)
   );

   Counter #(.Data_Width(DW)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .ld      (ctr_ld),
      .en      (ctr_en),
      .datain  (ctr_datain),
      .dataout (ctr_dataout)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned done_cyc;
      int unsigned n_en;
      int unsigned first_en;
      int unsigned last_en;
      int unsigned limit;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // One entry per expected completion; cycle numbers are absolute values of cyc
   task automatic push_exp(input int unsigned e, input int unsigned start, input int unsigned limit,
                           input int unsigned div, input int unsigned periods);
      int unsigned n, d, base;
      exp_t x;
      n = (limit + 256 - start) % 256;
      d = n * (div + 1) + 2;
      for (int k = 0; k < int'(periods); k++) begin
         base       = e + 32'(k) * d;
         x.done_cyc = base + d - 1;
         x.n_en     = n;
         x.first_en = base + div + 1;
         x.last_en  = base + n * (div + 1);
         x.limit    = limit;
         sb.push_back(x);
      end
   endtask

   // Pops the scoreboard on each done pulse and checks the finished period
   task automatic monitor_loop();
      int unsigned en_cnt = 0, first_en = 0, last_en = 0;
      exp_t x;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (ctr_ld) en_cnt = 0;
            if (ctr_en) begin
               if (en_cnt == 0) first_en = cyc;
               last_en = cyc;
               en_cnt++;
            end
            if (done) begin
               if (sb.size() == 0) begin
                  check_eq("spurious_done", 1, 0);
               end else begin
                  x = sb.pop_front();
                  check_eq("done_cyc", cyc, x.done_cyc);
                  check_eq("en_count", en_cnt, x.n_en);
                  check_eq("dataout_at_done", 32'(ctr_dataout), x.limit);
                  if (x.n_en > 0) begin
                     check_eq("first_en_cyc", first_en, x.first_en);
                     check_eq("last_en_cyc", last_en, x.last_en);
                  end
               end
               en_cnt = 0;
            end
         end
      end
   endtask

   task automatic issue(input int unsigned start, input int unsigned limit, input bit reload,
                        input int unsigned div, input int unsigned periods, output int unsigned e);
      @(negedge clk);
      cmd_if.cmd_start  = DW'(start);
      cmd_if.cmd_limit  = DW'(limit);
      cmd_if.cmd_reload = reload;
      cmd_if.cmd_div    = DIV_WIDTH'(div);
      cmd_if.cmd_valid  = 1'b1;
      #1 check_eq("ready_idle", 32'(cmd_if.cmd_ready), 1);
      @(posedge clk);
      #1;
      e = cyc;
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_start  = DW'($urandom);
      cmd_if.cmd_limit  = DW'($urandom);
      cmd_if.cmd_reload = ~reload;
      cmd_if.cmd_div    = DIV_WIDTH'($urandom);
      if (periods > 0) push_exp(e, start, limit, div, periods);
      @(negedge clk);
      #1;
      check_eq("load_cycle1", 32'(ctr_ld), 1);
      check_eq("datain_start", 32'(ctr_datain), start);
      check_eq("busy_cycle1", 32'(busy), 1);
   endtask

   task automatic wait_ready(input int unsigned e, input int unsigned bound, output int unsigned cnum);
      bit found = 1'b0;
      cnum = 0;
      for (int i = 0; i < int'(bound); i++) begin
         @(negedge clk);
         #1;
         if (cmd_if.cmd_ready) begin
            cnum  = cyc - e + 1;
            found = 1'b1;
            break;
         end
      end
      if (!found) check_eq("ready_timeout", 0, 1);
   endtask

   task automatic wait_value(input int unsigned v, input int unsigned bound, output bit found);
      found = 1'b0;
      for (int i = 0; i < int'(bound); i++) begin
         @(negedge clk);
         if (ctr_dataout == DW'(v) && !ctr_ld && busy) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) check_eq("value_timeout", 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned e, c;
      bit          found;
      rst               = 1'b1;
      abort             = 1'b0;
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_start  = '0;
      cmd_if.cmd_limit  = '0;
      cmd_if.cmd_reload = 1'b0;
      cmd_if.cmd_div    = '0;
      fork
         monitor_loop();
      join_none

      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_ready", 32'(cmd_if.cmd_ready), 1);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_ld", 32'(ctr_ld), 0);
      check_eq("rst_en", 32'(ctr_en), 0);
      check_eq("rst_datain", 32'(ctr_datain), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_aborted", 32'(aborted), 0);
      check_eq("rst_reload_cnt", 32'(reload_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      // One-shot 5 -> 12
      issue(5, 12, 1'b0, 0, 1, e);
      wait_ready(e, 50, c);
      check_eq("oneshot_ready_cyc", c, 11);
      check_eq("oneshot_final", 32'(ctr_dataout), 12);

      // Wrap 250 -> 3
      issue(250, 3, 1'b0, 0, 1, e);
      wait_ready(e, 50, c);
      check_eq("wrap_ready_cyc", c, 13);
      check_eq("wrap_final", 32'(ctr_dataout), 3);

      // Prescaled 0 -> 2, div 3
      issue(0, 2, 1'b0, 3, 1, e);
      wait_ready(e, 50, c);
      check_eq("presc_ready_cyc", c, 12);
      check_eq("presc_final", 32'(ctr_dataout), 2);

      // limit == start
      issue(7, 7, 1'b0, 0, 1, e);
      wait_ready(e, 50, c);
      check_eq("equal_ready_cyc", c, 4);
      check_eq("equal_final", 32'(ctr_dataout), 7);

      // Auto-reload 0 -> 4, host pokes while busy, abort in the 4th LOAD
      issue(0, 4, 1'b1, 0, 3, e);
      for (int k = 2; k <= 18; k++) begin
         @(negedge clk);
         if (k >= 3 && k <= 6) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_start = DW'($urandom);
            #1 check_eq("ready_while_busy", 32'(cmd_if.cmd_ready), 0);
         end else if (k == 7) begin
            cmd_if.cmd_valid = 1'b0;
         end
      end
      @(negedge clk);
      abort = 1'b1;
      #1;
      check_eq("reload_cnt_3", 32'(reload_cnt), 3);
      check_eq("abort_ld_forced", 32'(ctr_ld), 0);
      check_eq("abort_load_pulse", 32'(aborted), 1);
      check_eq("reload_sb_drained", 32'(sb.size()), 0);
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      #1;
      check_eq("abort_load_idle", 32'(busy), 0);
      check_eq("aborted_one_cycle", 32'(aborted), 0);
      check_eq("abort_load_hold", 32'(ctr_dataout), 4);

      // Abort in RUN at dataout 9
      issue(0, 20, 1'b0, 0, 0, e);
      wait_value(9, 40, found);
      if (found) begin
         abort = 1'b1;
         #1;
         check_eq("abort_run_pulse", 32'(aborted), 1);
         check_eq("abort_run_en", 32'(ctr_en), 0);
         check_eq("abort_run_done", 32'(done), 0);
         @(posedge clk);
         #1 abort = 1'b0;
         @(negedge clk);
         #1;
         check_eq("abort_run_idle", 32'(busy), 0);
         check_eq("abort_run_ready", 32'(cmd_if.cmd_ready), 1);
         repeat (3) @(negedge clk);
         #1 check_eq("abort_run_hold", 32'(ctr_dataout), 9);
      end

      // Abort coincident with terminal in auto-reload
      issue(0, 3, 1'b1, 0, 0, e);
      wait_value(3, 40, found);
      if (found) begin
         abort = 1'b1;
         #1;
         check_eq("abort_term_done", 32'(done), 0);
         check_eq("abort_term_pulse", 32'(aborted), 1);
         @(posedge clk);
         #1 abort = 1'b0;
         @(negedge clk);
         #1;
         check_eq("abort_term_reload", 32'(reload_cnt), 0);
         check_eq("abort_term_idle", 32'(busy), 0);
      end

      // Reset in the middle of an auto-reload run
      issue(1, 3, 1'b1, 0, 2, e);
      repeat (9) @(negedge clk);
      #1;
      check_eq("pre_rst_reload", 32'(reload_cnt), 2);
      check_eq("pre_rst_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_ready", 32'(cmd_if.cmd_ready), 1);
      check_eq("mid_rst_busy", 32'(busy), 0);
      check_eq("mid_rst_ld", 32'(ctr_ld), 0);
      check_eq("mid_rst_en", 32'(ctr_en), 0);
      check_eq("mid_rst_datain", 32'(ctr_datain), 0);
      check_eq("mid_rst_reload", 32'(reload_cnt), 0);
      check_eq("mid_rst_dataout", 32'(ctr_dataout), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("final_sb_empty", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
